// File: rtl/dma_mem_writer_if.sv
// DMA-side word stream and memory-side write/ack handshake of dma_mem_writer.
interface dma_mem_writer_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic              in_valid;
    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;

    // slave: the writer block itself; master: the DMA plus memory around it
    modport slave (
        input  in_valid, in_addr, in_data, mem_ack,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output in_valid, in_addr, in_data, mem_ack,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dma_mem_writer.sv
// Buffers the DMA (address, data) stream in a small FIFO and drains it into the
// CNN memory port with a write/ack handshake, flagging completion after io_done.
module dma_mem_writer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned PTR_W  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            io_done,
    dma_mem_writer_if.slave bus,
    output logic [15:0]     count,
    output logic            overflow,
    output logic            load_complete,
    output logic            busy
);
    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    entry_t            fifo_mem [DEPTH];
    entry_t            head;
    entry_t            in_word;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    occ;
    logic              done_seen;
    logic              not_empty;
    logic              ready;
    logic              push;
    logic              pop;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    assign in_word   = {bus.in_addr, bus.in_data};
    assign head      = fifo_mem[rd_ptr];
    assign not_empty = (occ != '0);
    // ready reflects occupancy before any same-cycle pop
    assign ready     = (occ != FULL) && (state != DONE);
    assign push      = bus.in_valid && ready;
    assign pop       = not_empty && ((state == IDLE) || ((state == WRITE) && bus.mem_ack));

    assign bus.in_ready  = ready;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign busy          = not_empty || (state == WRITE);

    // FIFO storage; a word arriving with start becomes slot 0 of the new session
    always_ff @(posedge clk) begin
        if (start) begin
            if (bus.in_valid) begin
                fifo_mem[0] <= in_word;
            end
        end else if (push) begin
            fifo_mem[wr_ptr] <= in_word;
        end
    end

    // Pointers, occupancy, drain FSM and status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            occ           <= '0;
            done_seen     <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            count         <= '0;
            overflow      <= 1'b0;
            load_complete <= 1'b0;
        end else if (start) begin
            state         <= IDLE;
            rd_ptr        <= '0;
            done_seen     <= 1'b0;
            mem_we        <= 1'b0;
            count         <= '0;
            overflow      <= 1'b0;
            load_complete <= 1'b0;
            if (bus.in_valid) begin
                wr_ptr <= PTR_W'(1);
                occ    <= (PTR_W + 1)'(1);
            end else begin
                wr_ptr <= '0;
                occ    <= '0;
            end
        end else begin
            if (io_done) begin
                done_seen <= 1'b1;
            end
            if (bus.in_valid && !ready) begin
                overflow <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + (PTR_W + 1)'(1);
                2'b01:   occ <= occ - (PTR_W + 1)'(1);
                default: ;
            endcase

            case (state)
                IDLE: begin
                    if (not_empty) begin
                        mem_addr  <= head.addr;
                        mem_wdata <= head.data;
                        mem_we    <= 1'b1;
                        state     <= WRITE;
                    end else if (done_seen) begin
                        load_complete <= 1'b1;
                        state         <= DONE;
                    end
                end
                WRITE: begin
                    if (bus.mem_ack) begin
                        count <= count + 16'd1;
                        if (not_empty) begin
                            mem_addr  <= head.addr;
                            mem_wdata <= head.data;
                        end else begin
                            mem_we <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                DONE: ;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_mem_writer.sv
// Randomised and directed stimulus for dma_mem_writer, checked by a queue-based
// reference model and a write monitor that consumes expected words.
module tb_dma_mem_writer;
    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 16;
    localparam int unsigned DEPTH = 8;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        start   = 1'b0;
    logic        io_done = 1'b0;
    logic [15:0] count;
    logic        overflow;
    logic        load_complete;
    logic        busy;

    dma_mem_writer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dma_mem_writer #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .PTR_W(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .io_done       (io_done),
        .bus           (bus),
        .count         (count),
        .overflow      (overflow),
        .load_complete (load_complete),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Words accepted but not yet committed, oldest first, as {addr, data}
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: buffered word count plus one in-flight slot
    int          m_fifo     = 0;
    bit          m_inflight = 1'b0;
    bit          m_seen     = 1'b0;
    bit          m_complete = 1'b0;
    bit          m_ovf      = 1'b0;
    logic [15:0] m_count    = '0;
    bit          m_ready;
    int          m_had;

    always @(negedge clk) begin
        if (rst) begin
            m_fifo = 0; m_inflight = 1'b0; m_seen = 1'b0;
            m_complete = 1'b0; m_ovf = 1'b0; m_count = '0;
            exp_q.delete();
        end
        m_ready = (m_fifo < int'(DEPTH)) && !m_complete;
        check("in_ready", 32'(bus.in_ready), 32'(m_ready));
        check("mem_we", 32'(bus.mem_we), 32'(m_inflight));
        check("busy", 32'(busy), 32'((m_fifo != 0) || m_inflight));
        check("count", 32'(count), 32'(m_count));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("load_complete", 32'(load_complete), 32'(m_complete));
        if (!rst) begin
            if (start) begin
                exp_q.delete();
                m_fifo = 0; m_inflight = 1'b0; m_seen = 1'b0;
                m_complete = 1'b0; m_ovf = 1'b0; m_count = '0;
                if (bus.in_valid) begin
                    m_fifo = 1;
                    exp_q.push_back({bus.in_addr, bus.in_data});
                end
            end else begin
                m_had = m_fifo;
                if (bus.in_valid && !m_ready) m_ovf = 1'b1;
                if (!m_inflight) begin
                    if (m_had > 0) begin
                        m_inflight = 1'b1;
                        m_fifo--;
                    end else if (m_seen) begin
                        m_complete = 1'b1;
                    end
                end else if (bus.mem_ack) begin
                    m_count = m_count + 16'd1;
                    if (m_had > 0) m_fifo--;
                    else m_inflight = 1'b0;
                end
                if (bus.in_valid && m_ready) begin
                    m_fifo++;
                    exp_q.push_back({bus.in_addr, bus.in_data});
                end
                if (io_done) m_seen = 1'b1;
            end
        end
    end

    // Write monitor: the presented word must be the oldest pending one; ack retires it
    always @(negedge clk) begin
        if (!rst && !start && bus.mem_we) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL write_unexpected: addr 0x%0h data 0x%0h, expected no write at %0t",
                         bus.mem_addr, bus.mem_wdata, $time);
            end else begin
                check("mem_addr", 32'(bus.mem_addr), 32'(exp_q[0][31:16]));
                check("mem_wdata", 32'(bus.mem_wdata), 32'(exp_q[0][15:0]));
                if (bus.mem_ack) void'(exp_q.pop_front());
            end
        end
    end

    int cyc_n    = 0;
    int ack_mode = 0;

    // Advance one cycle; ack for the next cycle follows ack_mode
    task automatic tick();
        @(posedge clk);
        #1;
        cyc_n++;
        case (ack_mode)
            0:       bus.mem_ack = 1'b0;
            1:       bus.mem_ack = 1'b1;
            2:       bus.mem_ack = (cyc_n % 5 == 0);
            default: bus.mem_ack = ($urandom_range(0, 9) < 6);
        endcase
    endtask

    task automatic drive(input bit v, input logic [15:0] a, input logic [15:0] d);
        bus.in_valid = v;
        bus.in_addr  = a;
        bus.in_data  = d;
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] d);
        drive(1'b1, a, d);
        tick();
        drive(1'b0, '0, '0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d words still pending after %0d cycles, expected 0", exp_q.size(), budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, '0, '0);
        bus.mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_load_complete", 32'(load_complete), 32'd0);
        rst = 1'b0;

        // Three words, zero-wait ack, then io_done
        ack_mode = 1;
        pulse_start();
        push(16'h0000, 16'hA5A5);
        push(16'h0001, 16'h5A5A);
        push(16'h0002, 16'h1234);
        io_done = 1'b1;
        idle(6);
        drain(20);
        check("s1_count", 32'(count), 32'd3);
        check("s1_complete", 32'(load_complete), 32'd1);
        check("s1_overflow", 32'(overflow), 32'd0);
        io_done = 1'b0;

        // Stalled ack, DEPTH words back to back
        ack_mode = 2;
        pulse_start();
        for (int i = 0; i < int'(DEPTH); i++) push(16'(16'h0100 + i), 16'($urandom));
        drain(80);
        io_done = 1'b1;
        idle(3);
        check("s2_count", 32'(count), 32'(DEPTH));
        check("s2_overflow", 32'(overflow), 32'd0);
        io_done = 1'b0;

        // Ack held low, FIFO overrun
        ack_mode = 0;
        pulse_start();
        for (int i = 0; i < 10; i++) push(16'(16'h0200 + i), 16'($urandom));
        idle(3);
        check("s3_overflow", 32'(overflow), 32'd1);
        ack_mode = 1;
        drain(30);
        idle(1);
        check("s3_count", 32'(count), 32'(m_count));

        // io_done while five words are still buffered
        ack_mode = 0;
        pulse_start();
        for (int i = 0; i < 6; i++) push(16'(16'h0300 + i), 16'($urandom));
        io_done = 1'b1;
        idle(4);
        check("s4_wait_complete", 32'(load_complete), 32'd0);
        ack_mode = 1;
        drain(20);
        idle(2);
        check("s4_complete", 32'(load_complete), 32'd1);
        check("s4_count", 32'(count), 32'd6);
        push(16'h03FF, 16'hDEAD);
        idle(1);
        check("s4_late_overflow", 32'(overflow), 32'd1);
        io_done = 1'b0;

        // start coinciding with mem_ack during WRITE
        ack_mode = 0;
        pulse_start();
        for (int i = 0; i < 3; i++) push(16'(16'h0400 + i), 16'($urandom));
        idle(2);
        ack_mode = 1;
        bus.mem_ack = 1'b1;
        pulse_start();
        ack_mode = 0;
        check("s5_mem_we", 32'(bus.mem_we), 32'd0);
        check("s5_count", 32'(count), 32'd0);
        check("s5_busy", 32'(busy), 32'd0);
        check("s5_complete", 32'(load_complete), 32'd0);

        // Asynchronous reset between edges while a write is outstanding
        pulse_start();
        for (int i = 0; i < 10; i++) push(16'(16'h0500 + i), 16'($urandom));
        ack_mode = 1;
        idle(3);
        ack_mode = 0;
        idle(1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("s6_mem_we", 32'(bus.mem_we), 32'd0);
        check("s6_count", 32'(count), 32'd0);
        check("s6_overflow", 32'(overflow), 32'd0);
        check("s6_complete", 32'(load_complete), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Random sessions with random ack, occasional restarts and late io_done
        ack_mode = 3;
        for (int s = 0; s < 4; s++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
            pulse_start();
            for (int c = 0; c < 60; c++) begin
                drive(1'($urandom_range(0, 9) < 4), 16'($urandom), 16'($urandom));
                start   = ($urandom_range(0, 49) == 0);
                io_done = (c > 45) && ($urandom_range(0, 2) == 0);
                tick();
            end
            drive(1'b0, '0, '0);
            start   = 1'b0;
            io_done = 1'b1;
            drain(60);
            idle(3);
            check("rnd_complete", 32'(load_complete), 32'd1);
            io_done = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
